// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter that shares one simple-bus master port between NUM_REQ requesters.
// Optional response watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_master_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0]      req_write,
   input  logic [NUM_REQ*32-1:0]   req_addr,
   input  logic [NUM_REQ*32-1:0]   req_wdata,
   input  logic [NUM_REQ*4-1:0]    req_wstrb,
   output logic [NUM_REQ-1:0]      req_busy,
   output logic [NUM_REQ-1:0]      req_done,
   output logic [NUM_REQ-1:0]      req_err,
   output logic [31:0]             req_rdata,
   output logic                    m_valid,
   output logic                    m_write,
   output logic [31:0]             m_addr,
   output logic [31:0]             m_wdata,
   output logic [3:0]              m_wstrb,
   input  logic                    m_ready,
   input  logic                    m_rvalid,
   input  logic [31:0]             m_rdata
);

   localparam int GW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [NUM_REQ-1:0]       pending_q, pending_d;
   logic [GW-1:0]            grant_q, grant_d;
   logic                     bus_write_q, bus_write_d;
   logic [31:0]              bus_addr_q, bus_addr_d;
   logic [31:0]              bus_wdata_q, bus_wdata_d;
   logic [3:0]               bus_wstrb_q, bus_wstrb_d;
   logic [NUM_REQ-1:0]       done_q, done_d;
   logic [31:0]              rdata_q, rdata_d;

   logic [NUM_REQ-1:0]       hold_write_q;
   logic [NUM_REQ-1:0][31:0] hold_addr_q;
   logic [NUM_REQ-1:0][31:0] hold_wdata_q;
   logic [NUM_REQ-1:0][3:0]  hold_wstrb_q;

   logic [NUM_REQ-1:0]       capture;
   logic [NUM_REQ-1:0]       grant_oh;
   logic [GW-1:0]            winner;
   logic                     response;
   logic                     timeout_hit;
   logic                     complete;

   // Round-robin search starting one past the previous grant, wrapping at NUM_REQ.
   function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] pend,
                                             input logic [GW-1:0]      last);
      logic [GW:0]   idx;
      logic [GW-1:0] pick;
      logic          found;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = {1'b0, last} + (GW+1)'(k);
         if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
         if (!found && pend[idx[GW-1:0]]) begin
            pick  = idx[GW-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      grant_oh          = '0;
      grant_oh[grant_q] = 1'b1;
   end

   assign winner   = rr_pick(pending_q, grant_q);
   assign req_busy = pending_q | ((state_q != S_IDLE) ? grant_oh : '0);
   assign capture  = req_valid & ~req_busy;

   // Read data is only accepted in WAIT; an rvalid coinciding with m_valid is ignored.
   assign response = bus_write_q ? m_ready : ((state_q == S_WAIT) && m_rvalid);
   assign complete = (state_q != S_IDLE) && (response || timeout_hit);

   always_comb begin
      // NOTE: every signal written here gets its default first, so no path can leave it unassigned and infer a latch.
      state_d     = state_q;
      pending_d   = pending_q | capture;
      grant_d     = grant_q;
      bus_write_d = bus_write_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_wstrb_d = bus_wstrb_q;
      done_d      = '0;
      rdata_d     = rdata_q;

      case (state_q)
         S_IDLE: begin
            // Arbitration waits out the req_done cycle, giving IDLE/ISSUE/done per write.
            if ((|pending_q) && (done_q == '0)) begin
               grant_d            = winner;
               pending_d[winner]  = 1'b0;
               bus_write_d        = hold_write_q[winner];
               bus_addr_d         = hold_addr_q[winner];
               bus_wdata_d        = hold_wdata_q[winner];
               bus_wstrb_d        = hold_wstrb_q[winner];
               state_d            = S_ISSUE;
            end
         end
         S_ISSUE, S_WAIT: begin
            if (complete) begin
               state_d          = S_IDLE;
               done_d[grant_q]  = 1'b1;
               if (!bus_write_q) rdata_d = response ? m_rdata : 32'hDEAD_BEEF;
            end else begin
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pending_q   <= '0;
         grant_q     <= GW'(NUM_REQ-1);
         bus_write_q <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_wstrb_q <= '0;
         done_q      <= '0;
         rdata_q     <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         pending_q   <= pending_d;
         grant_q     <= grant_d;
         bus_write_q <= bus_write_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wstrb_q <= bus_wstrb_d;
         done_q      <= done_d;
         rdata_q     <= rdata_d;
      end
   end

   // NOTE: holding registers are not reset; their contents are only consumed when pending is set.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (capture[i]) begin
            hold_write_q[i] <= req_write[i];
            hold_addr_q[i]  <= req_addr[32*i +: 32];
            hold_wdata_q[i] <= req_wdata[32*i +: 32];
            hold_wstrb_q[i] <= req_wstrb[4*i +: 4];
         end
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES+1);

   logic [CW-1:0]      cnt_q;
   logic [NUM_REQ-1:0] err_q, err_d;

   // cnt_q holds the number of ISSUE/WAIT cycles already elapsed before this one.
   assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES-1));

   always_comb begin
      err_d = '0;
      if (complete && !response) err_d[grant_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= '0;
      end else begin
         cnt_q <= (state_q == S_IDLE) ? '0 : cnt_q + CW'(1);
         err_q <= err_d;
      end
   end

   assign req_err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign req_err     = '0;
`endif

   assign m_valid   = (state_q == S_ISSUE);
   assign m_write   = m_valid & bus_write_q;
   assign m_wstrb   = m_valid ? bus_wstrb_q : 4'h0;
   assign m_addr    = bus_addr_q;
   assign m_wdata   = bus_wdata_q;
   assign req_done  = done_q;
   assign req_rdata = rdata_q;

endmodule

// File: doc/bus_master_arbiter.md
# bus_master_arbiter

Round-robin arbiter that shares the single simple-bus master port (m_valid/m_write/m_addr/m_wdata/m_wstrb in; m_ready/m_rvalid/m_rdata back) between NUM_REQ on-chip requesters, e.g. the test-controller port and a DMA/spike-loader engine.

- Each requester issues one-cycle request pulses; the arbiter latches them.
- Only one transaction is on the bus at a time. The arbiter drives m_valid for exactly one cycle per transaction.
- It waits for the interconnect's single-cycle-pipelined response, then routes completion and read data back to the owning requester.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT_CYCLES, 64, response watchdog limit (used only with BUS_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request pulse
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*32  byte address, requester i at [32*i+:32]
- req_wdata  in  NUM_REQ*32  write data, requester i at [32*i+:32]
- req_wstrb  in  NUM_REQ*4  byte enables, requester i at [4*i+:4]
- req_busy  out  NUM_REQ  request pending or in flight
- req_done  out  NUM_REQ  one-cycle completion pulse
- req_err  out  NUM_REQ  with req_done: timed out (always 0 without macro)
- req_rdata  out  32  read data, valid with any req_done for a read
- m_valid, m_write  out  1  bus request
- m_addr, m_wdata  out  32  bus address/data
- m_wstrb  out  4  bus byte enables
- m_ready  in  1  write completion
- m_rvalid  in  1  read data valid
- m_rdata  in  32  read data

## Operation
Request capture:
- At a clk edge with req_valid[i]=1 and req_busy[i]=0, the request fields are captured into holding register i, and pending[i] is set.
- A req_valid while req_busy[i]=1 is ignored (no effect, no error).
- req_busy[i] = pending[i] OR (granted requester is i and state≠IDLE).

FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any pending, select the winner by round-robin starting at last_grant+1 (mod NUM_REQ), then load m_addr/m_write/m_wdata/m_wstrb from its holding register. Clear pending[winner], set last_grant=winner, go to ISSUE.
- ISSUE: m_valid=1 for this single cycle.
  - Write with m_ready=1: complete, go to IDLE.
  - Otherwise go to WAIT.
- WAIT: m_valid=0.
  - Write completes on the first cycle with m_ready=1.
  - Read completes on the first cycle with m_rvalid=1; m_rdata is captured into req_rdata.
  - m_rvalid during ISSUE is ignored.

Completion:
- req_done[grant] pulses the cycle after the completing cycle. The FSM returns to IDLE in that same cycle.
- req_rdata holds its value until the next read completes.

Reset and outputs:
- In ISSUE/WAIT, m_wstrb is driven only in ISSUE and is 4'h0 otherwise; m_write is forced to 0 when m_valid=0.
- Reset values: all outputs 0, pending=0, state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first).
- Reset mid-transaction: the in-flight transaction and all pending requests are dropped without a req_done; m_valid drops asynchronously.

## Timing
- req_valid sampled at edge N → grant at edge N+1 → m_valid high during cycle N+1..N+2 (one cycle).
- Write with same-cycle m_ready: req_done in the cycle after m_valid. The minimum is 3 cycles from req_valid to req_done.
- Read with m_rvalid one cycle after m_valid: req_done/req_rdata two cycles after m_valid.
- Back-to-back throughput: one transaction per 3 cycles (IDLE, ISSUE, done) for writes and 4 cycles for reads.
- Simultaneous req_valid from all requesters: granted in round-robin order. No requester waits more than NUM_REQ-1 transactions.
- A requester may re-request in the cycle after its req_done (req_busy=0 then).

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - A counter of clog2(TIMEOUT_CYCLES+1) bits counts cycles in ISSUE+WAIT.
  - On reaching TIMEOUT_CYCLES without a response, the transaction completes with req_done=1 and req_err=1; for reads req_rdata=32'hDEAD_BEEF.
  - Any late m_ready/m_rvalid arriving in IDLE is ignored.
- BUS_ARB_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; req_err tied to 0.

## Test plan
- Single write: req 0 writes 0x1234_5678 to 0x4000_0010 with wstrb F and m_ready=1 same cycle → one m_valid pulse with exact fields; req_done[0] 3 cycles after req_valid; req_err=0.
- Single read: req 1 reads 0x4000_0000, interconnect returns rvalid+0xCAFE_F00D one cycle after m_valid → req_done[1] with req_rdata=0xCAFE_F00D; req_busy[1] low next cycle.
- Contention: requesters 0 and 1 pulse simultaneously, three rounds → bus order 0,1,0,1,0,1; each m_valid exactly one cycle; no back-to-back m_valid.
- Back-pressure: m_ready delayed 5 cycles → m_valid stays low in WAIT, req_done after ready; new req_valid on a busy requester is ignored (no extra bus transaction).
- Reset mid-read: assert rst_n=0 in WAIT → m_valid/req_busy/req_done 0 immediately; after release, req 0 wins first.
- BUS_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no rvalid → req_done+req_err at the timeout, req_rdata=0xDEAD_BEEF; next request proceeds normally.
